timer_dev: RTL and testbench

- Programmable countdown timer peripheral on the system bridge.
- Its IRQ output drives one bit of the cp0 intr[5:0] bus (intr[0] at top level).
- Three word registers, relative to the bridge-decoded base:
  - CTRL at word 0.
  - PRESET at word 1.
  - COUNT at word 2, read-only.
- Two counting modes: one-shot with a level interrupt, and auto-reload with a 1-cycle pulse interrupt.

---
 rtl/timer_dev_if.sv | 12 +
 rtl/timer_dev.sv | 131 +++++++++++++
 tb/tb_timer_dev.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_if.sv
// Bus port bundle for the countdown timer: word address, write strobe,
// write/read data and the interrupt line toward cp0.
interface timer_dev_if;
    logic [1:0]  addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output addr, output WE, output Din, input Dout, input IRQ);
    modport slave  (input addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_dev.sv
// Programmable countdown timer: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload. Optional tick prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_dev #(
    parameter int PRESCALE_DIV = 4
) (
    input logic         clk,
    input logic         clr,
    timer_dev_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_pend_q, irq_pend_d;
    logic        sw_wr;
    logic        tick;
    logic        auto_reload;

`ifdef TIMER_PRESCALE_EN
    logic [7:0] presc_q, presc_d;
    assign tick = (presc_q == 8'(PRESCALE_DIV - 1));
`else
    logic unused_div;
    assign unused_div = ^PRESCALE_DIV;
    assign tick = 1'b1;
`endif

    assign sw_wr       = bus.WE && (bus.addr == 2'd0 || bus.addr == 2'd1);
    assign auto_reload = (ctrl_q[2:1] == 2'd1);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_pend_d = irq_pend_q;
`ifdef TIMER_PRESCALE_EN
        presc_d    = presc_q;
`endif
        // auto-reload interrupt is a single-cycle pulse
        if (irq_pend_q && auto_reload)
            irq_pend_d = 1'b0;

        case (state_q)
            IDLE: if (ctrl_q[0]) state_d = LOAD;
            LOAD: begin
                count_d = preset_q;
`ifdef TIMER_PRESCALE_EN
                presc_d = 8'd0;
`endif
                state_d = ctrl_q[0] ? CNT : IDLE;
            end
            CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = IDLE;
                end else if (tick) begin
`ifdef TIMER_PRESCALE_EN
                    presc_d = 8'd0;
`endif
                    // PRESET=0 lands here on the first tick, same as PRESET=1
                    if (count_q <= 32'd1) begin
                        count_d = 32'd0;
                        state_d = INT;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end else begin
`ifdef TIMER_PRESCALE_EN
                    presc_d = presc_q + 8'd1;
`endif
                end
            end
            INT: begin
                irq_pend_d = 1'b1;
                if (auto_reload) begin
                    state_d = LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // software write wins over any hardware update of the written register
        if (sw_wr) begin
            state_d    = IDLE;
            irq_pend_d = 1'b0;
`ifdef TIMER_PRESCALE_EN
            presc_d    = 8'd0;
`endif
            if (bus.addr == 2'd0) ctrl_d   = bus.Din[3:0];
            else                  preset_d = bus.Din;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_pend_q <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            presc_q    <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_pend_q <= irq_pend_d;
`ifdef TIMER_PRESCALE_EN
            presc_q    <= presc_d;
`endif
        end
    end

    always_comb begin
        case (bus.addr)
            2'd0:    bus.Dout = {28'd0, ctrl_q};
            2'd1:    bus.Dout = preset_q;
            2'd2:    bus.Dout = count_q;
            default: bus.Dout = 32'd0;
        endcase
    end

    assign bus.IRQ = irq_pend_q & ctrl_q[3];
endmodule

// File: tb/tb_timer_dev.sv
// Randomized/directed bench for timer_dev; expected COUNT/IRQ/CTRL come from
// closed-form timing formulas of the timer behaviour.
module tb_timer_dev;
    logic clk;
    logic clr;
    int   checks;
    int   failures;

    timer_dev_if bus ();

    timer_dev #(.PRESCALE_DIV(4)) dut (.clk(clk), .clr(clr), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef TIMER_PRESCALE_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.WE   = 1'b1;
        bus.Din  = d;
        step();
        bus.WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.Dout;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        bus.WE = 1'b0;
        step();
        step();
        clr = 1'b0;
    endtask

    // Cycles spent counting down; PRESET=0 counts like PRESET=1.
    function automatic int cnt_len(input int p);
        return ((p == 0) ? 1 : p) * D;
    endfunction

    // COUNT in cycle t (t>=3) after the enabling CTRL write in cycle 0.
    function automatic logic [31:0] m_count(input int t, input int p, input bit m1);
        int n, u;
        n = cnt_len(p);
        u = m1 ? (t - 3) % (n + 2) : (t - 3);
        return (u < n) ? 32'(p - u / D) : 32'd0;
    endfunction

    function automatic logic m_irq(input int t, input int p, input bit m1, input bit im);
        int n;
        n = cnt_len(p);
        if (!im) return 1'b0;
        if (m1) return (t >= 3) && (((t - 3) % (n + 2)) == n + 1);
        return t >= n + 4;
    endfunction

    // Observe cycles 1..T after a CTRL write enabling the timer.
    task automatic run(input int p, input int mode, input bit im, input int T, input string tag);
        logic [31:0] v;
        bit m1;
        bit en;
        m1 = (mode == 1);
        for (int t = 1; t <= T; t++) begin
            rd(2'd2, v);
            if (t >= 3) chk({tag, "_count"}, v, m_count(t, p, m1));
            chk({tag, "_irq"}, {31'd0, bus.IRQ}, {31'd0, m_irq(t, p, m1, im)});
            rd(2'd0, v);
            en = m1 || (t < cnt_len(p) + 4);
            chk({tag, "_ctrl"}, v, {28'd0, im, 2'(mode), en});
            step();
        end
    endtask

    task automatic start(input int p, input int mode, input bit im, input string tag);
        int T;
        wr(2'd1, 32'(p));
        wr(2'd0, {28'd0, im, 2'(mode), 1'b1});
        T = (mode == 1) ? 3 * (cnt_len(p) + 2) + 4 : cnt_len(p) + 8;
        run(p, mode, im, T, tag);
    endtask

    initial begin
        logic [31:0] v;
        int p_tab[7]  = '{5, 3, 0, 1, 4, 2, 0};
        int m_tab[7]  = '{0, 1, 0, 1, 2, 3, 1};
        int im_tab[7] = '{1, 1, 1, 1, 1, 0, 0};
        checks = 0;
        failures = 0;
        clr = 1'b1;
        bus.addr = 2'd0;
        bus.WE = 1'b0;
        bus.Din = 32'd0;
        do_reset();

        // reset state
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk("reset_dout", v, 32'd0);
        end
        chk("reset_irq", {31'd0, bus.IRQ}, 32'd0);

        // reserved CTRL bits, read-only COUNT, unused addr 3
        wr(2'd0, 32'hFFFF_FFF0);
        rd(2'd0, v); chk("ctrl_rsvd", v, 32'd0);
        wr(2'd1, 32'hA5A5_0007);
        wr(2'd2, 32'h0000_1234);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd1, v); chk("preset_rw", v, 32'hA5A5_0007);
        rd(2'd2, v); chk("count_ro", v, 32'd0);
        rd(2'd3, v); chk("addr3", v, 32'd0);

        // directed table then random configurations
        for (int i = 0; i < 7; i++) begin
            do_reset();
            start(p_tab[i], m_tab[i], im_tab[i][0], "dir");
        end
        for (int i = 0; i < 6; i++) begin
            do_reset();
            start(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), "rnd");
        end

        // masked auto-reload, then unmask via CTRL write
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h3);
        run(3, 1, 1'b0, 14, "mask");
        wr(2'd0, 32'hB);
        run(3, 1, 1'b1, 3 * (cnt_len(3) + 2) + 4, "unmask");

        // one-shot IRQ dropped by a PRESET write, timer stays idle
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        for (int t = 1; t < cnt_len(2) + 5; t++) step();
        chk("drop_irq_hi", {31'd0, bus.IRQ}, 32'd1);
        wr(2'd1, 32'd2);
        for (int t = 0; t < 10; t++) begin
            chk("drop_irq_lo", {31'd0, bus.IRQ}, 32'd0);
            rd(2'd2, v); chk("drop_count", v, 32'd0);
            step();
        end
        rd(2'd0, v); chk("drop_ctrl", v, 32'h8);

        // clr in the middle of a countdown
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int t = 1; t < 3 + 2 * D; t++) step();
        rd(2'd2, v); chk("clr_pre_count", v, 32'd3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            chk("clr_dout", v, 32'd0);
        end
        chk("clr_irq", {31'd0, bus.IRQ}, 32'd0);
        for (int t = 0; t < 4; t++) begin
            step();
            rd(2'd2, v); chk("clr_count_hold", v, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
